// File: rtl/toy_fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : toy_fetch_queue_if
// Brief    : Fill and instruction-ack bundle for toy_fetch_queue; ack_pc
//            exists only when TOY_FETCH_QUEUE_PC_EN is defined.
// Revision : 1.0
// ============================================================================
interface toy_fetch_queue_if #(
    parameter int FETCH_WRITE_CHANNEL = 4,
    parameter int INST_READ_CHANNEL   = 4,
    parameter int INST_WIDTH          = 32,
    parameter int ADDR_WIDTH          = 32
);
    logic                                           fill_vld;
    logic [ADDR_WIDTH-1:0]                          fill_addr;
    logic [FETCH_WRITE_CHANNEL-1:0][INST_WIDTH-1:0] fill_pld;
    logic [INST_READ_CHANNEL-1:0]                   ack_vld;
    logic [INST_READ_CHANNEL-1:0]                   ack_rdy;
    logic [INST_READ_CHANNEL-1:0][INST_WIDTH-1:0]   ack_pld;
`ifdef TOY_FETCH_QUEUE_PC_EN
    logic [INST_READ_CHANNEL-1:0][ADDR_WIDTH-1:0]   ack_pc;

    modport master (
        output fill_vld, fill_addr, fill_pld, ack_rdy,
        input  ack_vld, ack_pld, ack_pc
    );
    modport slave (
        input  fill_vld, fill_addr, fill_pld, ack_rdy,
        output ack_vld, ack_pld, ack_pc
    );
`else
    modport master (
        output fill_vld, fill_addr, fill_pld, ack_rdy,
        input  ack_vld, ack_pld
    );
    modport slave (
        input  fill_vld, fill_addr, fill_pld, ack_rdy,
        output ack_vld, ack_pld
    );
`endif
endinterface
`default_nettype wire

// File: rtl/toy_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : toy_fetch_queue
// Brief    : Halfword fetch queue presenting in-order 16/32-bit instructions;
//            optional per-channel PC under TOY_FETCH_QUEUE_PC_EN.
// Revision : 1.0
// ============================================================================
module toy_fetch_queue #(
    parameter int DEPTH               = 128,
    parameter int FETCH_WRITE_CHANNEL = 4,
    parameter int INST_READ_CHANNEL   = 4,
    parameter int INST_WIDTH          = 32,
    parameter int ADDR_WIDTH          = 32
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          clear,
    toy_fetch_queue_if.slave   bus,
    output logic               overflow
);
    localparam int AW      = $clog2(DEPTH);
    localparam int PW      = AW + 1;
    localparam int OW      = $clog2(FETCH_WRITE_CHANNEL) + 1;
    localparam int LINE_HW = 2 * FETCH_WRITE_CHANNEL;
    localparam int RC      = INST_READ_CHANNEL;

    localparam logic [PW-1:0] C_ONE   = PW'(1);
    localparam logic [PW-1:0] C_TWO   = PW'(2);
    localparam logic [PW-1:0] C_DEPTH = PW'(DEPTH);
    localparam logic [PW-1:0] C_LINE  = PW'(LINE_HW);

    logic [15:0]   r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic          r_overflow;

    logic [PW-1:0] w_cnt;
    logic [PW-1:0] w_free;
    logic [OW-1:0] w_fill_off;
    logic [PW-1:0] w_fill_n;
    logic [PW-1:0] w_wr_base;
    logic          w_fill_ok;
    logic [PW-1:0] w_consume;
    logic          w_unused_addr;

    assign w_cnt         = r_wr_ptr - r_rd_ptr;
    assign w_free        = C_DEPTH - w_cnt;
    assign w_fill_off    = bus.fill_addr[OW:1];
    assign w_fill_n      = C_LINE - PW'(w_fill_off);
    // clear empties the queue this cycle, so a coincident fill always fits
    assign w_fill_ok     = bus.fill_vld && (clear || (w_free >= w_fill_n));
    assign w_wr_base     = clear ? '0 : r_wr_ptr;
    assign w_unused_addr = ^bus.fill_addr;
    assign overflow      = r_overflow;

`ifdef TOY_FETCH_QUEUE_PC_EN
    logic [RC-1:0][PW-1:0] w_start;
`endif

    // Serial length decode from rd_ptr; the first incomplete slot stops all later ones
    always_comb begin
        logic [PW-1:0] s;
        logic [PW-1:0] len;
        logic [15:0]   lo;
        logic [15:0]   hi;
        logic          live;
        logic          take;
        s           = '0;
        len         = C_ONE;
        lo          = '0;
        hi          = '0;
        live        = 1'b1;
        take        = 1'b1;
        w_consume   = '0;
        bus.ack_vld = '0;
        bus.ack_pld = '0;
`ifdef TOY_FETCH_QUEUE_PC_EN
        w_start     = '0;
`endif
        for (int i = 0; i < RC; i++) begin
            lo  = r_mem[AW'(r_rd_ptr + s)];
            hi  = r_mem[AW'(r_rd_ptr + s + C_ONE)];
            len = (lo[1:0] == 2'b11) ? C_TWO : C_ONE;
`ifdef TOY_FETCH_QUEUE_PC_EN
            w_start[i] = s;
`endif
            if (live && ((s + len) <= w_cnt)) begin
                bus.ack_vld[i] = 1'b1;
                bus.ack_pld[i] = (len == C_TWO) ? {hi, lo} : {16'h0000, lo};
                if (take && bus.ack_rdy[i]) begin
                    w_consume = w_consume + len;
                end else begin
                    take = 1'b0;
                end
            end else begin
                live = 1'b0;
                take = 1'b0;
            end
            s = s + len;
        end
    end

    // Storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (w_fill_ok) begin
            for (int k = 0; k < LINE_HW; k++) begin
                if (k >= int'(w_fill_off)) begin
                    r_mem[AW'(w_wr_base + PW'(k) - PW'(w_fill_off))] <=
                        bus.fill_pld[k/2][16*(k%2) +: 16];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (clear) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= w_fill_ok ? w_fill_n : '0;
            end else begin
                r_rd_ptr <= r_rd_ptr + w_consume;
                if (w_fill_ok) begin
                    r_wr_ptr <= r_wr_ptr + w_fill_n;
                end
            end
            if (bus.fill_vld && !w_fill_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef TOY_FETCH_QUEUE_PC_EN
    logic [ADDR_WIDTH-1:0] r_pc_base;
    logic                  r_pc_loaded;

    // Before the first fill the queue is empty, so loading never races a consume
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_base   <= '0;
            r_pc_loaded <= 1'b0;
        end else if (clear) begin
            r_pc_loaded <= w_fill_ok;
            if (w_fill_ok) begin
                r_pc_base <= bus.fill_addr;
            end
        end else if (w_fill_ok && !r_pc_loaded) begin
            r_pc_base   <= bus.fill_addr;
            r_pc_loaded <= 1'b1;
        end else begin
            r_pc_base <= r_pc_base + ADDR_WIDTH'({w_consume, 1'b0});
        end
    end

    for (genvar i = 0; i < RC; i++) begin : g_pc
        assign bus.ack_pc[i] = r_pc_base + ADDR_WIDTH'({w_start[i], 1'b0});
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_toy_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_toy_fetch_queue
// Brief    : Self-checking bench for toy_fetch_queue (halfword scoreboard model).
// Revision : 1.0
// ============================================================================
module tb_toy_fetch_queue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic overflow;

    always #5 clk = ~clk;

    toy_fetch_queue_if bus ();

    toy_fetch_queue dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .bus      (bus),
        .overflow (overflow)
    );

    typedef struct {
        bit           fv;
        logic [31:0]  addr;
        logic [127:0] line;
        logic [3:0]   rdy;
        logic [3:0]   exp_vld;
        int           exp_cnt;
    } vec_t;

    vec_t        tbl [13];
    logic [15:0] mq [$];
    bit          m_ovf = 1'b0;
    int          n_pass = 0;
    int          n_total = 0;

    logic [127:0] line_a, line_b, line_c, line_d, line_e;

    always @(posedge clk) begin : a_therm
        logic [3:0] r1;
        r1 = bus.ack_rdy + 4'd1;
        if (rst_n) assert ((r1 & bus.ack_rdy) == 4'b0000) else $error("ack_rdy not thermometer");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Expected view of the queue head, from the halfword scoreboard
    task automatic model_decode(input logic [3:0] rdy, output logic [3:0] vld,
                                output logic [3:0][31:0] pld, output int cons);
        int  s;
        int  len;
        bit  alive;
        bit  calive;
        s = 0; alive = 1; calive = 1;
        vld = '0; pld = '0; cons = 0;
        for (int i = 0; i < 4; i++) begin
            if (alive && s < mq.size()) begin
                len = (mq[s][1:0] == 2'b11) ? 2 : 1;
                if (s + len <= mq.size()) begin
                    vld[i] = 1'b1;
                    pld[i] = (len == 2) ? {mq[s+1], mq[s]} : {16'h0000, mq[s]};
                    if (calive && rdy[i]) cons += len;
                    else calive = 0;
                end else begin
                    alive = 0;
                end
                s += len;
            end else begin
                alive = 0;
            end
        end
    endtask

    task automatic step(input bit fv, input logic [31:0] addr, input logic [127:0] line,
                        input logic [3:0] rdy, input bit clr,
                        input bit use_exp, input logic [3:0] exp_vld, input int exp_cnt);
        logic [3:0]       ev;
        logic [3:0][31:0] ep;
        int               cons;
        int               o;
        int               n;
        bit               acc;
        @(negedge clk);
        bus.fill_vld  = fv;
        bus.fill_addr = addr;
        bus.fill_pld  = line;
        bus.ack_rdy   = rdy;
        clear         = clr;
        #1;
        model_decode(rdy, ev, ep, cons);
        chk("ack_vld", {124'd0, bus.ack_vld}, {124'd0, ev});
        chk("ack_pld", bus.ack_pld, ep);
        chk("overflow", {127'd0, overflow}, {127'd0, m_ovf});
        chk("cnt", {120'd0, dut.w_cnt}, 128'(mq.size()));
        if (use_exp) begin
            chk("tbl_vld", {124'd0, bus.ack_vld}, {124'd0, exp_vld});
            chk("tbl_cnt", {120'd0, dut.w_cnt}, 128'(exp_cnt));
        end
        @(posedge clk);
        o = int'(addr[3:1]);
        n = 8 - o;
        if (clr) begin
            mq.delete();
            acc = fv;
        end else begin
            acc = fv && ((128 - mq.size()) >= n);
            if (fv && !acc) m_ovf = 1'b1;
            repeat (cons) void'(mq.pop_front());
        end
        if (acc) for (int k = o; k < 8; k++) mq.push_back(line[16*k +: 16]);
        #1;
        bus.fill_vld = 1'b0;
        clear        = 1'b0;
    endtask

    // Random line whose 32-bit instructions never straddle the line end
    function automatic logic [127:0] rand_line();
        logic [127:0] l;
        logic [15:0]  h;
        int           p;
        l = '0;
        p = 0;
        while (p < 8) begin
            h = 16'($urandom);
            if (p < 7 && h[15]) begin
                l[16*p +: 16] = {h[14:2], 3'b011};
                h = 16'($urandom);
                l[16*(p+1) +: 16] = {h[15:2], 2'b00};
                p += 2;
            end else begin
                l[16*p +: 16] = {h[15:2], 1'b0, h[0]};
                p += 1;
            end
        end
        return l;
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        line_a = {32'hA4A4_0043, 32'hA3A3_0033, 32'hA2A2_0023, 32'hA1A1_0013};
        line_b = {16'hB072, 16'hB061, 16'hB05F, 16'hB043, 16'hB030, {3{16'hFFFF}}};
        line_c = {16'hC023, 16'hC010, {6{16'hFFFF}}};
        line_d = {16'hD710, 16'hD610, 16'hD510, 16'hD410, 16'hD310, 16'hD210, 16'hD110, 16'hD0FF};
        line_e = {16'hE710, 16'hE610, 16'hE510, 16'hE410, 16'hE310, 16'hE210, 16'hE1FF, 16'hE0FF};

        tbl[0]  = '{1'b0, 32'h0, 128'd0,  4'b0000, 4'b0000, 0};
        tbl[1]  = '{1'b1, 32'h0, line_a,  4'b1111, 4'b0000, 0};
        tbl[2]  = '{1'b0, 32'h0, 128'd0,  4'b1111, 4'b1111, 8};
        tbl[3]  = '{1'b1, 32'h6, line_b,  4'b0000, 4'b0000, 0};
        tbl[4]  = '{1'b0, 32'h0, 128'd0,  4'b0000, 4'b1111, 5};
        tbl[5]  = '{1'b0, 32'h0, 128'd0,  4'b1111, 4'b1111, 5};
        tbl[6]  = '{1'b0, 32'h0, 128'd0,  4'b0000, 4'b0000, 0};
        tbl[7]  = '{1'b1, 32'hC, line_c,  4'b0000, 4'b0000, 0};
        tbl[8]  = '{1'b1, 32'h0, line_d,  4'b0000, 4'b0001, 2};
        tbl[9]  = '{1'b0, 32'h0, 128'd0,  4'b0001, 4'b1111, 10};
        tbl[10] = '{1'b0, 32'h0, 128'd0,  4'b1111, 4'b1111, 9};
        tbl[11] = '{1'b0, 32'h0, 128'd0,  4'b1111, 4'b1111, 4};
        tbl[12] = '{1'b0, 32'h0, 128'd0,  4'b0000, 4'b0000, 0};

        bus.fill_vld  = 1'b0;
        bus.fill_addr = '0;
        bus.fill_pld  = '0;
        bus.ack_rdy   = '0;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vld", {124'd0, bus.ack_vld}, 128'd0);
        chk("rst_pld", bus.ack_pld, 128'd0);
        chk("rst_ovf", {127'd0, overflow}, 128'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++)
            step(tbl[i].fv, tbl[i].addr, tbl[i].line, tbl[i].rdy, 1'b0,
                 1'b1, tbl[i].exp_vld, tbl[i].exp_cnt);
        chk("b_pld1", {96'd0, bus.ack_pld[1]}, 128'd0);

        // Fill to capacity across the index wrap, then a dropped fill under consume
        for (int k = 0; k < 16; k++) step(1'b1, 32'h0, rand_line(), 4'b0000, 1'b0, 1'b0, '0, 0);
        chk("full_cnt", {120'd0, dut.w_cnt}, 128'd128);
        step(1'b1, 32'h0, rand_line(), 4'b1111, 1'b0, 1'b0, '0, 0);
        chk("ovf_set", {127'd0, overflow}, 128'd1);
        for (int c = 0; c < 80 && mq.size() > 0; c++) begin
            if (c % 5 == 2) step(1'b1, 32'h2, rand_line(), 4'b1111, 1'b0, 1'b0, '0, 0);
            else            step(1'b0, 32'h0, 128'd0,      4'b1111, 1'b0, 1'b0, '0, 0);
        end
        chk("drained", {120'd0, dut.w_cnt}, 128'd0);

        // clear with a coincident fill and acks
        step(1'b1, 32'h0, rand_line(), 4'b0000, 1'b0, 1'b0, '0, 0);
        step(1'b1, 32'h4, line_e, 4'b1111, 1'b1, 1'b0, '0, 0);
        chk("clr_rdptr", {120'd0, dut.r_rd_ptr}, 128'd0);
        chk("clr_cnt", {120'd0, dut.w_cnt}, 128'd6);
        chk("clr_pld0", {96'd0, bus.ack_pld[0]}, 128'h0000_E210);
`ifdef TOY_FETCH_QUEUE_PC_EN
        chk("clr_pc0", {96'd0, bus.ack_pc[0]}, 128'h4);
        chk("clr_pc1", {96'd0, bus.ack_pc[1]}, 128'h6);
`endif
        step(1'b0, 32'h0, 128'd0, 4'b0011, 1'b0, 1'b0, '0, 0);
        step(1'b0, 32'h0, 128'd0, 4'b0000, 1'b0, 1'b0, '0, 0);
        chk("ovf_sticky", {127'd0, overflow}, 128'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
